// File: rtl/raf_job_ctrl.sv
// Job sequencer: header read from the FIFO, then N payload bytes handed to the worker.
// Latency 3N+3 cycles start->done; worker backpressure holds PAY_HOLD, FIFO empty stalls reads.
module raf_job_ctrl #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic         abort,
    input  logic         empty,
    input  logic [W-1:0] q,
    output logic         rdreq,
    output logic [W-1:0] bc,
    output logic         Enwrk,
    output logic [W-1:0] dout,
    output logic         dvalid,
    input  logic         dready,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_RD,
        S_HDR_WAIT,
        S_PAY_RD,
        S_PAY_WAIT,
        S_PAY_HOLD,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   bc_q, bc_d;
    logic [W-1:0]   dout_q, dout_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic           rd_phase;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            bc_q    <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bc_q    <= bc_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bc_d     = bc_q;
        dout_d   = dout_q;
        cnt_d    = cnt_q;
        rd_phase = (state_q == S_HDR_RD) || (state_q == S_PAY_RD);
        busy     = (state_q != S_IDLE);
        // abort kills the handshakes in the same cycle it is seen
        rdreq    = rd_phase && !empty && !abort;
        dvalid   = (state_q == S_PAY_HOLD) && !abort;
        Enwrk    = (state_q == S_PAY_RD) || (state_q == S_PAY_WAIT) ||
                   (state_q == S_PAY_HOLD);
        done     = (state_q == S_DONE) && !abort;

        if (busy && abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:     if (start && !abort) state_d = S_HDR_RD;
                S_HDR_RD:   if (rdreq) state_d = S_HDR_WAIT;
                S_HDR_WAIT: begin
                    bc_d    = q;
                    cnt_d   = q;
                    state_d = (q == '0) ? S_DONE : S_PAY_RD;
                end
                S_PAY_RD:   if (rdreq) state_d = S_PAY_WAIT;
                S_PAY_WAIT: begin
                    dout_d  = q;
                    state_d = S_PAY_HOLD;
                end
                S_PAY_HOLD: begin
                    // leaving at cnt==1 keeps the counter from ever wrapping
                    if (dready) begin
                        cnt_d   = cnt_q - W'(1);
                        state_d = (cnt_q == W'(1)) ? S_DONE : S_PAY_RD;
                    end
                end
                S_DONE:     state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    assign bc   = bc_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_raf_job_ctrl.sv
// Bench for raf_job_ctrl: FIFO/worker model plus a job-level reference model checked every cycle.
module tb_raf_job_ctrl;

    logic       CLK, RST, start, abort, empty, dready;
    logic [7:0] q;
    logic       rdreq, Enwrk, dvalid, busy, done;
    logic [7:0] bc, dout;

    raf_job_ctrl #(.W(8)) dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort), .empty(empty), .q(q),
        .rdreq(rdreq), .bc(bc), .Enwrk(Enwrk), .dout(dout), .dvalid(dvalid),
        .dready(dready), .busy(busy), .done(done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // external FIFO model
    logic [7:0] fifo[$];
    bit         hold_empty = 1'b0;
    bit         pop_req    = 1'b0;
    logic [7:0] pop_val    = 8'h00;

    // reference model: where the job is, in terms of what it still needs
    bit         armed = 1'b0;
    bit         m_active, m_want_rd, m_pend, m_hold, m_pay, m_done;
    logic [7:0] m_pend_val, m_bc, m_dout;
    int         m_left;

    // observations of the DUT, compared against literal expectations by the directed tests
    int         cyc_n = 0, cnt_rdreq = 0, cnt_hs = 0, cnt_done = 0, cnt_en = 0;
    int         start_cyc = 0, done_cyc = 0, enwrk_rise = 0, enwrk_last = 0;
    bit         prev_en = 1'b0;
    logic [7:0] hs_log[$];

    always @(negedge CLK) begin
        bit e_rdreq, e_dvalid, e_enwrk, e_busy, e_done;
        e_rdreq = 1'b0;
        cyc_n++;
        if (armed) begin
            e_busy   = m_active;
            e_rdreq  = m_active && m_want_rd && !empty && !abort;
            e_dvalid = m_active && m_hold && !abort;
            e_enwrk  = m_active && m_pay;
            e_done   = m_active && m_done && !abort;
            chk("busy",   busy,   e_busy);
            chk("rdreq",  rdreq,  e_rdreq);
            chk("dvalid", dvalid, e_dvalid);
            chk("Enwrk",  Enwrk,  e_enwrk);
            chk("done",   done,   e_done);
            chk("bc",     bc,     m_bc);
            chk("dout",   dout,   m_dout);

            if (rdreq === 1'b1) cnt_rdreq++;
            if (dvalid === 1'b1 && dready) begin cnt_hs++; hs_log.push_back(dout); end
            if (done === 1'b1) begin cnt_done++; done_cyc = cyc_n; end
            if (Enwrk === 1'b1) begin
                cnt_en++;
                enwrk_last = cyc_n;
                if (!prev_en) enwrk_rise = cyc_n;
            end
            prev_en = (Enwrk === 1'b1);

            if (e_rdreq) begin pop_req = 1'b1; pop_val = fifo[0]; end

            if (!m_active) begin
                if (start && !abort) begin
                    m_active = 1'b1; m_want_rd = 1'b1; start_cyc = cyc_n;
                end
            end else if (abort) begin
                m_active = 1'b0; m_want_rd = 1'b0; m_pend = 1'b0;
                m_hold = 1'b0; m_pay = 1'b0; m_done = 1'b0;
            end else if (m_done) begin
                m_active = 1'b0; m_done = 1'b0;
            end else if (m_want_rd) begin
                if (e_rdreq) begin m_want_rd = 1'b0; m_pend = 1'b1; m_pend_val = pop_val; end
            end else if (m_pend) begin
                m_pend = 1'b0;
                if (!m_pay) begin
                    m_bc = m_pend_val; m_left = int'(m_pend_val);
                    if (m_left == 0) m_done = 1'b1;
                    else begin m_pay = 1'b1; m_want_rd = 1'b1; end
                end else begin
                    m_dout = m_pend_val; m_hold = 1'b1;
                end
            end else if (m_hold && dready) begin
                m_hold = 1'b0; m_left--;
                if (m_left == 0) begin m_done = 1'b1; m_pay = 1'b0; end
                else m_want_rd = 1'b1;
            end
        end
        if (RST) begin
            armed = 1'b1; m_active = 1'b0; m_want_rd = 1'b0; m_pend = 1'b0;
            m_hold = 1'b0; m_pay = 1'b0; m_done = 1'b0; m_bc = 8'h00; m_dout = 8'h00;
            m_left = 0; prev_en = 1'b0;
        end
    end

    task automatic step();
        empty = hold_empty || (fifo.size() == 0);
        @(posedge CLK);
        #1;
        if (pop_req) begin
            void'(fifo.pop_front());
            q = pop_val;
            pop_req = 1'b0;
        end
    endtask

    task automatic wait_done(input int bound, input string nm);
        int d0 = cnt_done;
        int k  = 0;
        while (cnt_done == d0 && k < bound) begin step(); k++; end
        if (cnt_done == d0) begin
            total++; bad++;
            $display("FAIL %s_timeout: got no done after %0d cycles, required a done pulse", nm, bound);
        end
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int r0, d0, e0, k;
        RST = 1'b1; start = 1'b0; abort = 1'b0; dready = 1'b1; q = 8'h00; empty = 1'b1;
        step(); step();
        RST = 1'b0;
        chk("rst_busy", busy, 0); chk("rst_rdreq", rdreq, 0); chk("rst_dvalid", dvalid, 0);
        chk("rst_Enwrk", Enwrk, 0); chk("rst_done", done, 0); chk("rst_bc", bc, 0);
        chk("rst_dout", dout, 0);

        // three-byte job, worker always ready
        fifo = '{8'd3, 8'h11, 8'h22, 8'h33};
        hs_log.delete(); r0 = cnt_rdreq; d0 = cnt_done;
        kick();
        wait_done(40, "t1");
        step(); step();
        chk("t1_rdreqs", cnt_rdreq - r0, 4);
        chk("t1_hs_n", hs_log.size(), 3);
        if (hs_log.size() == 3) begin
            chk("t1_b0", hs_log[0], 8'h11); chk("t1_b1", hs_log[1], 8'h22); chk("t1_b2", hs_log[2], 8'h33);
        end
        chk("t1_bc", bc, 3);
        chk("t1_dones", cnt_done - d0, 1);
        chk("t1_latency", done_cyc - start_cyc, 12);
        chk("t1_en_rise", enwrk_rise - start_cyc, 3);
        chk("t1_en_last", done_cyc - enwrk_last, 1);

        // empty job
        fifo = '{8'd0};
        hs_log.delete(); e0 = cnt_en;
        kick();
        wait_done(20, "t2");
        chk("t2_bc", bc, 0); chk("t2_hs", hs_log.size(), 0); chk("t2_en", cnt_en - e0, 0);
        chk("t2_latency", done_cyc - start_cyc, 3);

        // worker backpressure on the first byte
        fifo = '{8'd2, 8'h07, 8'h04};
        hs_log.delete();
        kick();
        k = 0;
        while (dvalid !== 1'b1 && k < 20) begin step(); k++; end
        dready = 1'b0; r0 = cnt_rdreq;
        repeat (5) step();
        chk("t3_stall_rdreq", cnt_rdreq - r0, 0); chk("t3_hold_dvalid", dvalid, 1);
        chk("t3_hold_dout", dout, 8'h07);
        dready = 1'b1;
        wait_done(30, "t3");
        chk("t3_hs_n", hs_log.size(), 2);
        if (hs_log.size() == 2) begin chk("t3_b0", hs_log[0], 8'h07); chk("t3_b1", hs_log[1], 8'h04); end
        chk("t3_latency", done_cyc - start_cyc, 14);

        // FIFO empty when the header is wanted
        fifo = '{8'd1, 8'h78};
        hold_empty = 1'b1; hs_log.delete(); r0 = cnt_rdreq;
        kick();
        repeat (4) begin chk("t4_busy", busy, 1); step(); end
        chk("t4_no_rdreq", cnt_rdreq - r0, 0);
        hold_empty = 1'b0;
        wait_done(30, "t4");
        chk("t4_latency", done_cyc - start_cyc, 10);
        chk("t4_hs_n", hs_log.size(), 1);
        if (hs_log.size() == 1) chk("t4_b0", hs_log[0], 8'h78);

        // abort in the second PAY_HOLD, then the next word is a header
        fifo = '{8'd4, 8'h0A, 8'h0B, 8'h01, 8'h66};
        r0 = cnt_hs; d0 = cnt_done;
        kick();
        k = 0;
        while (!(cnt_hs - r0 == 1 && dvalid === 1'b1) && k < 30) begin step(); k++; end
        abort = 1'b1;
        #1;
        chk("t5_abort_dvalid", dvalid, 0); chk("t5_abort_rdreq", rdreq, 0);
        step();
        abort = 1'b0;
        chk("t5_idle", busy, 0);
        step(); step();
        chk("t5_no_done", cnt_done - d0, 0);
        hs_log.delete();
        kick();
        wait_done(20, "t5");
        chk("t5_bc", bc, 1);
        chk("t5_hs_n", hs_log.size(), 1);
        if (hs_log.size() == 1) chk("t5_b0", hs_log[0], 8'h66);

        // reset mid-job, then start+abort in IDLE
        fifo = '{8'd2, 8'h31, 8'h32};
        kick();
        k = 0;
        while (!(Enwrk === 1'b1 && dvalid === 1'b0 && rdreq === 1'b0) && k < 20) begin step(); k++; end
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("t6_busy", busy, 0); chk("t6_bc", bc, 0); chk("t6_dout", dout, 0);
        chk("t6_Enwrk", Enwrk, 0); chk("t6_dvalid", dvalid, 0); chk("t6_done", done, 0);
        fifo.delete();
        step();
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("t6_start_abort", busy, 0);

        // randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            if (fifo.size() < 4) begin
                int n = $urandom_range(0, 5);
                fifo.push_back(8'(n));
                for (int j = 0; j < n; j++) fifo.push_back(8'($urandom_range(0, 255)));
            end
            start      = ($urandom_range(0, 3) == 0);
            dready     = ($urandom_range(0, 9) < 7);
            hold_empty = ($urandom_range(0, 9) == 0);
            abort      = ($urandom_range(0, 59) == 0);
            step();
        end
        start = 1'b0; abort = 1'b1; hold_empty = 1'b0; dready = 1'b1;
        step();
        abort = 1'b0;
        chk("end_idle", busy, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
